alu_arb_seq: RTL and testbench

ALU_ARB_SEQ -- requirements
Module: alu_arb_seq

---
 rtl/alu_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 16 +
 rtl/alu_arb_seq.sv | 128 ++++++++++++
 tb/tb_alu_arb_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the arbitrated ALU sequencer: default widths,
// opcode values understood by the external ALU, and the FSM encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 6;
  localparam int ALU_OPW   = 3;

  // Opcodes are only meaningful to the external ALU; the sequencer forwards
  // them untouched.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LT  = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } seq_state_e;

endpackage : alu_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. last_grant names the requester served most
// recently; on a tie the other one wins. Output is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Single requester wins outright; a tie goes to the one not served last.
  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | last_grant);
    grant[1] = req[1] & (~req[0] | ~last_grant);
  end

endmodule : rr_arb2

// File: rtl/alu_arb_seq.sv
// Two requesters share one combinational ALU. A granted request is latched,
// presented to the ALU for one cycle, and the result is held until the
// consumer takes it.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | arbitrate; accept at most one request per cycle
//   ST_EXEC | latched operands drive the ALU; capture alu_y
//   ST_RESP | rsp_valid high, result/id held until rsp_ready
module alu_arb_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_y,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y
);

  seq_state_e       state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [OPW-1:0]   op_q;
  logic             id_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] rsp_y_q;
  logic             rsp_valid_q;

  logic [1:0]       grant;
  logic             accept;
  logic [WIDTH-1:0] a_d, b_d;
  logic [OPW-1:0]   op_d;

  rr_arb2 u_rr_arb2 (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Handshake only exists in IDLE; grant is already qualified by valid.
  always_comb begin
    accept     = (state_q == ST_IDLE) && (grant != 2'b00);
    req0_ready = (state_q == ST_IDLE) && grant[0];
    req1_ready = (state_q == ST_IDLE) && grant[1];
  end

  // Select the winning requester's operands for latching.
  always_comb begin
    a_d  = grant[1] ? req1_a  : req0_a;
    b_d  = grant[1] ? req1_b  : req0_b;
    op_d = grant[1] ? req1_op : req0_op;
  end

  // Sequencer FSM with its datapath registers and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_y_q      <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= grant[1];
            last_grant_q <= grant[1];
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_y_q     <= alu_y;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          // Returning to IDLE here means the freed cycle cannot also accept.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // ALU sees only latched values so requesters may change freely in flight.
  always_comb begin
    alu_a     = a_q;
    alu_b     = b_q;
    alu_op    = op_q;
    rsp_valid = rsp_valid_q;
    rsp_id    = id_q;
    rsp_y     = rsp_y_q;
  end

endmodule : alu_arb_seq

// File: tb/tb_alu_arb_seq.sv
// Directed bench for alu_arb_seq with a behavioural ALU on the shared port.
module tb_alu_arb_seq;
  import alu_pkg::*;

  localparam int W = 6;
  localparam int O = 3;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [O-1:0] req0_op, req1_op;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [O-1:0] alu_op;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_y;

  int n_checks = 0;
  int n_errors = 0;

  alu_arb_seq #(.WIDTH(W), .OPW(O)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_y      (alu_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU attached to the shared port.
  always_comb begin
    alu_y = '0;
    case (alu_op)
      OP_ADD: alu_y = alu_a + alu_b;
      OP_SUB: alu_y = alu_a - alu_b;
      OP_AND: alu_y = alu_a & alu_b;
      OP_OR:  alu_y = alu_a | alu_b;
      OP_XOR: alu_y = alu_a ^ alu_b;
      OP_LT:  alu_y = ($signed(alu_a) < $signed(alu_b)) ? W'(1) : W'(0);
      OP_SHL: alu_y = alu_a << alu_b[2:0];
      OP_SHR: alu_y = alu_a >> alu_b[2:0];
      default: alu_y = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;

    // Reset values
    #2;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_req0_ready", req0_ready, 0);

    // Single request: -3 < 2 signed
    next_cycle();
    rst_n = 1'b1;
    req0_valid = 1; req0_a = 6'h3D; req0_b = 6'h02; req0_op = OP_LT;
    #1;
    chk("single_req0_ready", req0_ready, 1);
    chk("single_req1_ready", req1_ready, 0);
    next_cycle();
    req0_valid = 0;
    #1;
    chk("single_exec_ready", req0_ready, 0);
    chk("single_exec_valid", rsp_valid, 0);
    chk("single_exec_alu_a", alu_a, 6'h3D);
    chk("single_exec_alu_op", alu_op, OP_LT);
    next_cycle(); #1;
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_y", rsp_y, 6'h01);
    chk("single_rsp_id", rsp_id, 0);
    next_cycle(); #1;
    chk("single_idle_valid", rsp_valid, 0);

    // Simultaneous requests from reset: grants 0,1,0,1
    rst_n = 1'b0;
    #1;
    chk("rst2_rsp_valid", rsp_valid, 0);
    next_cycle();
    rst_n = 1'b1;
    req0_valid = 1; req0_a = 6'd5;  req0_b = 6'd3;  req0_op = OP_ADD;
    req1_valid = 1; req1_a = 6'd12; req1_b = 6'd10; req1_op = OP_SUB;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_req0_ready", req0_ready, (k % 2 == 0) ? 1 : 0);
      chk("rr_req1_ready", req1_ready, (k % 2 == 1) ? 1 : 0);
      next_cycle(); #1;
      chk("rr_exec_alu_a", alu_a, (k % 2 == 0) ? 6'd5 : 6'd12);
      next_cycle(); #1;
      chk("rr_rsp_valid", rsp_valid, 1);
      chk("rr_rsp_id", rsp_id, (k % 2 == 0) ? 0 : 1);
      chk("rr_rsp_y", rsp_y, (k % 2 == 0) ? 6'd8 : 6'd2);
      chk("rr_resp_no_ready", {req1_ready, req0_ready}, 0);
      next_cycle();
    end

    // Backpressure: tie goes to req0 (last grant was req1)
    req0_a = 6'h2A; req0_b = 6'h0F; req0_op = OP_XOR;
    #1;
    chk("bp_req0_ready", req0_ready, 1);
    chk("bp_req1_ready", req1_ready, 0);
    next_cycle();
    rsp_ready = 0;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_y", rsp_y, 6'h25);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_hold_no_ready", {req1_ready, req0_ready}, 0);
      next_cycle();
    end
    rsp_ready = 1;
    #1;
    chk("bp_release_valid", rsp_valid, 1);
    chk("bp_release_no_ready", {req1_ready, req0_ready}, 0);
    next_cycle(); #1;
    chk("bp_idle_valid", rsp_valid, 0);
    chk("bp_idle_req1_ready", req1_ready, 1);
    chk("bp_idle_req0_ready", req0_ready, 0);
    req0_valid = 0; req1_valid = 0;

    // Reset during EXEC (last grant is req0 before reset)
    next_cycle();
    req0_valid = 1; req0_a = 6'd1; req0_b = 6'd1; req0_op = OP_ADD;
    #1;
    chk("rm_req0_ready", req0_ready, 1);
    next_cycle();
    req0_valid = 0;
    rst_n = 0;
    #1;
    chk("rm_rst_valid", rsp_valid, 0);
    chk("rm_rst_alu_a", alu_a, 0);
    chk("rm_rst_rsp_y", rsp_y, 0);
    next_cycle();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rm_no_rsp", rsp_valid, 0);
      next_cycle();
    end
    req0_valid = 1; req0_a = 6'h11; req0_b = 6'h22; req0_op = OP_OR;
    req1_valid = 1; req1_a = 6'h01; req1_b = 6'h01; req1_op = OP_ADD;
    #1;
    chk("rm_tie_req0", req0_ready, 1);
    chk("rm_tie_req1", req1_ready, 0);
    next_cycle();
    req0_valid = 0; req1_valid = 0;
    next_cycle(); #1;
    chk("rm_rsp_y", rsp_y, 6'h33);
    chk("rm_rsp_id", rsp_id, 0);
    next_cycle();

    // Isolation: requester operands change while in flight
    req0_valid = 1; req0_a = 6'h07; req0_b = 6'h05; req0_op = OP_AND;
    rsp_ready = 0;
    #1;
    chk("iso_req0_ready", req0_ready, 1);
    next_cycle();
    req0_valid = 0; req0_a = 6'h3F; req0_b = 6'h00; req0_op = OP_OR;
    #1;
    chk("iso_exec_alu_a", alu_a, 6'h07);
    chk("iso_exec_alu_op", alu_op, OP_AND);
    next_cycle();
    req0_a = 6'h15;
    #1;
    chk("iso_rsp_y", rsp_y, 6'h05);
    chk("iso_rsp_alu_a", alu_a, 6'h07);
    rsp_ready = 1;
    next_cycle(); #1;
    chk("iso_idle_valid", rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_alu_arb_seq
